seq_mag_comparator: RTL
=======================

Name: seq_mag_comparator

Overview:
- Parametrised, multi-cycle magnitude comparator.
- Accepts two WIDTH-bit operands via a valid/ready handshake and scans them MSB-first, CHUNK bits per cycle.
- Supports unsigned and two's-complement signed compare, with optional early exit on the first differing chunk.
- Produces registered AeqB/AltB/AgtB flags under an output valid/ready handshake; intended for datapaths where WIDTH is too large for a single-cycle compare.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits compared per cycle; 1 <= CHUNK <= WIDTH.
- EARLY_EXIT, 1, 1 = finish on first differing chunk; 0 = always scan all NCH = WIDTH/CHUNK chunks (constant latency).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and mode valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled at accept.
- abort  input  1  synchronous cancel of the in-flight compare.
- out_valid  output  1  result flags valid.
- out_ready  input  1  consumer takes the result.
- AeqB  output  1  A == B.
- AltB  output  1  A < B.
- AgtB  output  1  A > B.
- busy  output  1  high in SCAN or HOLD.

Behaviour:
- Reset (async, rst_n low): state = IDLE; out_valid, AeqB, AltB, AgtB, busy = 0; in_ready = 1; operand and chunk-index registers = 0.
- States:
  - IDLE: in_ready = 1. On in_valid && in_ready, capture a, b and signed_mode; clear the chunk index; go to SCAN.
  - SCAN: each cycle, compare chunk k (k = 0 is the MSB chunk) of the captured operands.
    - First differing chunk: record gt/lt.
    - EARLY_EXIT = 1: go to HOLD at that edge.
    - EARLY_EXIT = 0: keep the first recorded difference and ignore later chunks.
    - Last chunk (k = NCH-1): go to HOLD; if no difference was recorded, the result is eq.
  - HOLD: out_valid = 1. Exactly one of AeqB/AltB/AgtB is 1, and all are stable until out_ready. On out_ready: clear out_valid and the flags, go to IDLE.
- Signed mode: invert the MSB of both operands at capture (offset binary), then compare as unsigned.
- Latency, counted in edges from the accept edge to out_valid high:
  - EARLY_EXIT = 1: j+1, where j is the index of the first differing chunk; NCH if A == B.
  - EARLY_EXIT = 0: always NCH.
- Throughput: at most one compare in flight. in_ready = 0 in SCAN and HOLD; in_valid is ignored there.
- The first new accept occurs on the edge after HOLD->IDLE. There is no HOLD->SCAN bypass.
- Flags are 0 whenever out_valid = 0.
- abort:
  - In SCAN or HOLD: next state is IDLE, out_valid and flags are cleared, and no result is produced.
  - abort takes priority over out_ready and over the SCAN->HOLD transition.
  - In IDLE: abort is ignored; a simultaneous accept proceeds.
- Reset mid-operation: immediately returns to the reset values; the captured operands are discarded.
- NCH = 1 (CHUNK = WIDTH): latency is 1 edge regardless of EARLY_EXIT.
- Chunk index width: clog2(NCH), minimum 1 bit; the index never wraps past NCH-1.

Decomposition:
- Package cmp_pkg:
  - state enum (IDLE, SCAN, HOLD);
  - result encoding localparams (RES_EQ, RES_LT, RES_GT);
  - function for NCH / index width.
- Sub-module chunk_cmp:
  - combinational CHUNK-bit unsigned compare with outputs eq and gt (lt = !eq && !gt);
  - one instance, fed by a mux that selects chunk k.

Test Plan (WIDTH=16, CHUNK=4 unless noted):
- Reset held low 3 cycles, then released -> in_ready = 1; out_valid, AeqB, AltB, AgtB, busy = 0; no spurious out_valid within 10 cycles of idle.
- Unsigned, a=0x8000, b=0x7FFF, EARLY_EXIT=1 -> AgtB = 1 with out_valid 1 edge after accept. Same stimulus with EARLY_EXIT=0 -> AgtB = 1 after 4 edges.
- Signed, a=0x8000 (-32768), b=0x7FFF -> AltB = 1. Signed, a=0xFFFF (-1), b=0x0000 -> AltB = 1. Unsigned, a=0xFFFF, b=0x0000 -> AgtB = 1.
- a=b=0x1234 -> AeqB = 1, out_valid after 4 edges. Then a=0x1234, b=0x1235 -> AltB = 1 after 4 edges (difference in the last chunk).
- Back-pressure: out_ready low 5 cycles in HOLD, in_valid held high with new operands -> flags stable, in_ready = 0, no accept. out_ready high -> IDLE, then the new operands are accepted on the following edge.
- a=0x1230, b=0x1234, abort pulsed on the 2nd SCAN cycle -> out_valid never rises; in_ready = 1 the next cycle. Repeat with abort and out_ready both high in HOLD -> result dropped, IDLE.

Source files
------------

// File: rtl/cmp_pkg.sv
// -----------------------------------------------------------------------------
// cmp_pkg
// Shared types and helpers for the sequential magnitude comparator.
//   state_t      : controller states (IDLE / SCAN / HOLD)
//   RES_*        : one-hot result encodings, bit order {gt, lt, eq}
//   calc_nch     : number of chunks scanned per compare
//   calc_idx_w   : chunk-index width (never below 1 bit)
// -----------------------------------------------------------------------------
package cmp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic [2:0] RES_EQ = 3'b001;
   localparam logic [2:0] RES_LT = 3'b010;
   localparam logic [2:0] RES_GT = 3'b100;

   function automatic int calc_nch(input int width, input int chunk);
      return width / chunk;
   endfunction

   function automatic int calc_idx_w(input int nch);
      return (nch <= 1) ? 1 : $clog2(nch);
   endfunction

endpackage

// File: rtl/chunk_cmp.sv
// -----------------------------------------------------------------------------
// chunk_cmp
// Combinational unsigned compare of one CHUNK-bit slice.
//   a_chunk, b_chunk : slices under compare
//   eq               : a_chunk == b_chunk
//   gt               : a_chunk >  b_chunk   (lt is implied by !eq && !gt)
// -----------------------------------------------------------------------------
module chunk_cmp #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a_chunk,
   input  logic [CHUNK-1:0] b_chunk,
   output logic             eq,
   output logic             gt
);

   assign eq = (a_chunk == b_chunk);
   assign gt = (a_chunk >  b_chunk);

endmodule

// File: rtl/seq_mag_comparator.sv
// -----------------------------------------------------------------------------
// seq_mag_comparator
// Multi-cycle magnitude comparator scanning operands MSB chunk first.
//   clk, rst_n           : clock, async active-low reset
//   in_valid / in_ready  : operand handshake (a, b, signed_mode sampled here)
//   abort                : cancels an in-flight compare (SCAN or HOLD)
//   out_valid / out_ready: result handshake
//   AeqB, AltB, AgtB     : registered one-hot result, zero when !out_valid
//   busy                 : high in SCAN or HOLD
// -----------------------------------------------------------------------------
module seq_mag_comparator
   import cmp_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int CHUNK      = 4,
   parameter int EARLY_EXIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_mode,
   input  logic             abort,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             AeqB,
   output logic             AltB,
   output logic             AgtB,
   output logic             busy
);

   localparam int NCH   = calc_nch(WIDTH, CHUNK);
   localparam int IDX_W = calc_idx_w(NCH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               diff_q, diff_d;     // a differing chunk has been seen
   logic               dgt_q, dgt_d;       // direction of that first difference
   logic               out_valid_q, out_valid_d;
   logic [2:0]         flags_q, flags_d;   // {gt, lt, eq}

   logic [CHUNK-1:0]   a_chunk, b_chunk;
   logic               c_eq, c_gt;
   logic               last_chunk;
   logic               finish;
   logic [WIDTH-1:0]   a_cap, b_cap;

   // Chunk k = 0 is the most significant slice.
   always_comb begin
      a_chunk = '0;
      b_chunk = '0;
      for (int k = 0; k < NCH; k++) begin
         if (idx_q == IDX_W'(k)) begin
            a_chunk = a_q[(NCH-1-k)*CHUNK +: CHUNK];
            b_chunk = b_q[(NCH-1-k)*CHUNK +: CHUNK];
         end
      end
   end

   chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
      .a_chunk (a_chunk),
      .b_chunk (b_chunk),
      .eq      (c_eq),
      .gt      (c_gt)
   );

   // Signed compare: flipping both MSBs maps two's complement onto offset
   // binary, so the unsigned scan gives the signed ordering.
   always_comb begin
      a_cap = a;
      b_cap = b;
      a_cap[WIDTH-1] = a[WIDTH-1] ^ signed_mode;
      b_cap[WIDTH-1] = b[WIDTH-1] ^ signed_mode;
   end

   assign last_chunk = (idx_q == LAST_IDX);
   assign finish     = last_chunk || ((EARLY_EXIT != 0) && !c_eq);

   // NOTE: every variable gets a default before the case so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      idx_d       = idx_q;
      diff_d      = diff_q;
      dgt_d       = dgt_q;
      out_valid_d = out_valid_q;
      flags_d     = flags_q;

      unique case (state_q)
         IDLE: begin
            // abort is deliberately ignored here.
            if (in_valid) begin
               a_d     = a_cap;
               b_d     = b_cap;
               idx_d   = '0;
               diff_d  = 1'b0;
               dgt_d   = 1'b0;
               state_d = SCAN;
            end
         end

         SCAN: begin
            if (abort) begin
               state_d = IDLE;
            end else begin
               if (!diff_q && !c_eq) begin
                  diff_d = 1'b1;
                  dgt_d  = c_gt;
               end
               if (finish) begin
                  state_d     = HOLD;
                  out_valid_d = 1'b1;
                  // The earliest recorded difference wins over the current chunk.
                  if (diff_q)     flags_d = dgt_q ? RES_GT : RES_LT;
                  else if (!c_eq) flags_d = c_gt  ? RES_GT : RES_LT;
                  else            flags_d = RES_EQ;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end

         HOLD: begin
            if (abort || out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
               flags_d     = '0;
            end
         end

         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            flags_d     = '0;
         end
      endcase
   end

   // NOTE: state uses non-blocking assignments so every flop samples the
   // pre-edge values; the operand registers are reset too so a reset
   // mid-compare leaves no stale data behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         idx_q       <= '0;
         diff_q      <= 1'b0;
         dgt_q       <= 1'b0;
         out_valid_q <= 1'b0;
         flags_q     <= '0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         idx_q       <= idx_d;
         diff_q      <= diff_d;
         dgt_q       <= dgt_d;
         out_valid_q <= out_valid_d;
         flags_q     <= flags_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = out_valid_q;
   assign AeqB      = |(flags_q & RES_EQ);
   assign AltB      = |(flags_q & RES_LT);
   assign AgtB      = |(flags_q & RES_GT);

endmodule
